// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-port arbiter: FSM encoding,
// a constant-foldable clog2 helper and the statistics counter width.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    localparam int STAT_W = 16;

    // Smallest r such that 2**r >= value; usable in port and parameter widths.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first asserted request
// searching upward from last+1, wrapping modulo NREQ. The last index itself
// is searched last, so a lone requester can win again.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]        req,
    input  logic [clog2(NREQ)-1:0] last,
    output logic [clog2(NREQ)-1:0] next,
    output logic                   found
);

    localparam int IW = clog2(NREQ);

    logic [IW-1:0] idx;

    // Scan candidates in priority order and keep the first hit.
    always_comb begin
        // NOTE: every output of a combinational block gets a default before any
        // conditional assignment; otherwise synthesis infers a latch.
        next  = last;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = IW'((int'(last) + k) % NREQ);
            if (!found && req[idx]) begin
                found = 1'b1;
                next  = idx;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter for the write port of the async FIFO.
// Lives entirely in the wclk domain; wfull is honoured combinationally.
// A grant lasts until a beat with last set or MAX_BURST accepted beats.
// Optional feature: define FIFO_WR_ARB_STATS_EN to add the stat_beats port,
// one 16-bit wrapping accepted-beat counter per requester.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int DSIZE     = 8,
    parameter int MAX_BURST = 16
) (
    input  logic                   wclk,
    input  logic                   wrst,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*DSIZE-1:0]  req_data,
    input  logic [NREQ-1:0]        req_last,
    output logic [NREQ-1:0]        req_ready,
    input  logic                   arb_en,
    input  logic                   wfull,
    output logic                   winc,
    output logic [DSIZE-1:0]       wdata,
    output logic [clog2(NREQ)-1:0] gnt_id,
    output logic                   busy
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    output logic [NREQ*STAT_W-1:0] stat_beats
`endif
);

    localparam int IW = clog2(NREQ);
    localparam int CW = clog2(MAX_BURST + 1);

    arb_state_t    state_q, state_d;
    logic [IW-1:0] gnt_q, gnt_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] pick_idx;
    logic          pick_found;
    logic          xfer;

    rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req   (req_valid),
        .last  (gnt_q),
        .next  (pick_idx),
        .found (pick_found)
    );

    // State register: FSM state, current/last grant and beat count.
    always_ff @(posedge wclk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its pre-edge inputs, independent of statement order.
        if (wrst) begin
            state_q <= IDLE;
            gnt_q   <= IW'(NREQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic plus the combinational handshake toward the FIFO.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        cnt_d     = cnt_q;
        xfer      = (state_q == BURST) && req_valid[gnt_q] && !wfull;
        winc      = xfer;
        req_ready = '0;
        req_ready[gnt_q] = xfer;

        unique case (state_q)
            IDLE: begin
                if (arb_en && pick_found) begin
                    gnt_d   = pick_idx;
                    cnt_d   = '0;
                    state_d = BURST;
                end
            end
            BURST: begin
                if (xfer) begin
                    if (req_last[gnt_q] || (cnt_q == CW'(MAX_BURST - 1))) begin
                        // Release; the count is cleared so it never reaches MAX_BURST.
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
        endcase
    end

    assign wdata  = req_data[int'(gnt_q) * DSIZE +: DSIZE];
    assign gnt_id = gnt_q;
    assign busy   = (state_q == BURST);

`ifdef FIFO_WR_ARB_STATS_EN
    logic [STAT_W-1:0] stat_q [NREQ];

    // Per-requester accepted-beat counters, wrapping at 2**STAT_W.
    always_ff @(posedge wclk) begin
        // NOTE: this array is architectural state read by software, so it is
        // reset explicitly; plain data storage arrays normally stay unreset.
        if (wrst) begin
            for (int i = 0; i < NREQ; i++) begin
                stat_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (req_ready[i]) begin
                    stat_q[i] <= stat_q[i] + 1'b1;
                end
            end
        end
    end

    // Flatten the counters onto the output bus.
    always_comb begin
        stat_beats = '0;
        for (int i = 0; i < NREQ; i++) begin
            stat_beats[i*STAT_W +: STAT_W] = stat_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter. Each requester owns a queue of
// beats; a transaction-level model predicts grants, handshakes and data.
module tb_fifo_wr_arbiter;

    localparam int NREQ      = 4;
    localparam int DSIZE     = 8;
    localparam int MAX_BURST = 16;
    localparam int IW        = 2;

    typedef struct packed {
        logic [DSIZE-1:0] data;
        logic             last;
    } beat_t;

    logic                  wclk;
    logic                  wrst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*DSIZE-1:0] req_data;
    logic [NREQ-1:0]       req_last;
    logic [NREQ-1:0]       req_ready;
    logic                  arb_en;
    logic                  wfull;
    logic                  winc;
    logic [DSIZE-1:0]      wdata;
    logic [IW-1:0]         gnt_id;
    logic                  busy;
`ifdef FIFO_WR_ARB_STATS_EN
    logic [NREQ*16-1:0]    stat_beats;
`endif

    fifo_wr_arbiter #(
        .NREQ      (NREQ),
        .DSIZE     (DSIZE),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .wclk      (wclk),
        .wrst      (wrst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .arb_en    (arb_en),
        .wfull     (wfull),
        .winc      (winc),
        .wdata     (wdata),
        .gnt_id    (gnt_id),
        .busy      (busy)
`ifdef FIFO_WR_ARB_STATS_EN
        ,
        .stat_beats(stat_beats)
`endif
    );

    initial begin
        wclk = 1'b0;
        forever #5 wclk = ~wclk;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int checks   = 0;
    int failures = 0;

    beat_t           q [NREQ][$];
    logic [NREQ-1:0] vmask;

    // Reference model state.
    bit m_known;
    bit m_busy;
    int m_gnt;
    int m_cnt;
    int m_stat [NREQ];

    // Observations from the most recent cycle.
    logic            obs_busy;
    logic            obs_winc;
    logic [NREQ-1:0] obs_ready;
    logic [IW-1:0]   obs_gnt;
    bit              prev_busy;
    int              prev_gnt;
    int              obs_len;
    int              winc_cnt;
    int              obs_grants [$];
    int              obs_bgnt [$];
    int              obs_blen [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic push_burst(input int r, input int len);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.data = DSIZE'($urandom);
            b.last = (i == len - 1);
            q[r].push_back(b);
        end
    endtask

    function automatic int pending();
        int n;
        n = 0;
        for (int i = 0; i < NREQ; i++) n += q[i].size();
        return n;
    endfunction

    // Present each unmasked requester's queue head; idle lanes carry junk.
    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            if (vmask[i] && q[i].size() > 0) begin
                req_valid[i]                 = 1'b1;
                req_data[i*DSIZE +: DSIZE]   = q[i][0].data;
                req_last[i]                  = q[i][0].last;
            end else begin
                req_valid[i]                 = 1'b0;
                req_data[i*DSIZE +: DSIZE]   = DSIZE'($urandom);
                req_last[i]                  = 1'($urandom);
            end
        end
    endtask

    // One clock: drive, compare at negedge, advance the model, step the edge.
    task automatic cycle();
        bit              exp_xfer;
        logic [NREQ-1:0] exp_ready;
        bit              lst;
        drive();
        @(negedge wclk);
        obs_busy  = busy;
        obs_winc  = winc;
        obs_ready = req_ready;
        obs_gnt   = gnt_id;
        exp_xfer  = m_busy && req_valid[m_gnt] && !wfull;
        exp_ready = '0;
        if (exp_xfer) exp_ready[m_gnt] = 1'b1;
        if (m_known) begin
            check("busy", busy, m_busy);
            check("winc", winc, exp_xfer);
            check("req_ready", req_ready, exp_ready);
            check("gnt_id", gnt_id, m_gnt);
            if (exp_xfer) check("wdata", wdata, q[m_gnt][0].data);
            if (busy && !prev_busy) obs_grants.push_back(int'(gnt_id));
            if (winc) begin
                obs_len++;
                winc_cnt++;
            end
            if (!busy && prev_busy) begin
                obs_bgnt.push_back(prev_gnt);
                obs_blen.push_back(obs_len);
                obs_len = 0;
            end
            prev_busy = busy;
            prev_gnt  = int'(gnt_id);
        end
        if (exp_xfer) begin
            lst = q[m_gnt][0].last;
            void'(q[m_gnt].pop_front());
            m_stat[m_gnt] = (m_stat[m_gnt] + 1) % 65536;
            m_cnt++;
            if (lst || m_cnt == MAX_BURST) begin
                m_busy = 1'b0;
                m_cnt  = 0;
            end
        end else if (!m_busy && arb_en && req_valid != '0) begin
            for (int k = 1; k <= NREQ; k++) begin
                if (req_valid[(m_gnt + k) % NREQ]) begin
                    m_gnt = (m_gnt + k) % NREQ;
                    break;
                end
            end
            m_busy = 1'b1;
            m_cnt  = 0;
        end
        if (wrst) begin
            m_busy  = 1'b0;
            m_gnt   = NREQ - 1;
            m_cnt   = 0;
            m_known = 1'b1;
            for (int i = 0; i < NREQ; i++) m_stat[i] = 0;
        end
        @(posedge wclk);
        #1;
    endtask

    task automatic run_drain(input string tag, input int budget, output int n);
        vmask  = '1;
        wfull  = 1'b0;
        arb_en = 1'b1;
        n = 0;
        while ((pending() > 0 || m_busy) && n < budget) begin
            cycle();
            n++;
        end
        check({tag, "_drained"}, 32'(n < budget), 1);
        cycle();
    endtask

    task automatic wait_size(input string tag, input int r, input int sz, input int budget);
        int n;
        n = 0;
        while (q[r].size() != sz && n < budget) begin
            cycle();
            n++;
        end
        check({tag, "_reached"}, 32'(n < budget), 1);
    endtask

    initial begin
        int       n;
        int       low;
        int       pushed;
        logic [4:0] trace;
        int       exp_t2 [5];
        int       exp_t3g [5];
        int       exp_t3l [5];
        beat_t    b;

        exp_t2  = '{0, 1, 2, 3, 0};
        exp_t3g = '{2, 3, 0, 2, 2};
        exp_t3l = '{16, 2, 2, 16, 8};

        wrst      = 1'b1;
        arb_en    = 1'b1;
        wfull     = 1'b0;
        vmask     = '0;
        m_known   = 1'b0;
        m_busy    = 1'b0;
        m_gnt     = NREQ - 1;
        m_cnt     = 0;
        prev_busy = 1'b0;
        prev_gnt  = 0;
        obs_len   = 0;
        winc_cnt  = 0;
        for (int i = 0; i < NREQ; i++) m_stat[i] = 0;

        // Reset state.
        repeat (2) cycle();
        wrst = 1'b0;
        check("rst_busy", obs_busy, 0);
        check("rst_winc", obs_winc, 0);
        check("rst_ready", obs_ready, 0);
        check("rst_gnt", obs_gnt, NREQ - 1);

        // Single 3-beat burst from requester 0: one cycle of latency.
        push_burst(0, 3);
        vmask = 4'b0001;
        trace = '0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            trace = {trace[3:0], obs_winc};
        end
        check("t1_winc_trace", trace, 5'b01110);
        check("t1_gnt", obs_gnt, 0);
        check("t1_idle", obs_busy, 0);

        // All requesters, single-beat bursts, fresh from reset.
        wrst = 1'b1;
        cycle();
        wrst = 1'b0;
        obs_grants.delete();
        push_burst(0, 1);
        push_burst(0, 1);
        for (int i = 1; i < NREQ; i++) push_burst(i, 1);
        run_drain("t2", 100, n);
        check("t2_cycles", n, 10);
        check("t2_ngrants", obs_grants.size(), 5);
        for (int i = 0; i < 5 && i < obs_grants.size(); i++) check("t2_order", obs_grants[i], exp_t2[i]);

        // 40-beat stream from requester 2 with forced releases.
        obs_bgnt.delete();
        obs_blen.delete();
        push_burst(2, 40);
        push_burst(0, 2);
        push_burst(3, 2);
        run_drain("t3", 200, n);
        check("t3_nbursts", obs_bgnt.size(), 5);
        for (int i = 0; i < 5 && i < obs_bgnt.size(); i++) begin
            check("t3_burst_gnt", obs_bgnt[i], exp_t3g[i]);
            check("t3_burst_len", obs_blen[i], exp_t3l[i]);
        end

        // Backpressure: wfull high for 5 cycles mid-burst.
        winc_cnt = 0;
        push_burst(1, 10);
        vmask = 4'b0010;
        wait_size("t4", 1, 7, 30);
        wfull = 1'b1;
        low = 0;
        repeat (5) begin
            cycle();
            if (!obs_winc && obs_ready == '0) low++;
        end
        wfull = 1'b0;
        check("t4_stall", low, 5);
        run_drain("t4", 100, n);
        check("t4_beats", winc_cnt, 10);

        // Reset during beat 2 of a burst from requester 2.
        push_burst(2, 6);
        vmask = 4'b0100;
        wait_size("t5", 2, 5, 30);
        wrst = 1'b1;
        cycle();
        wrst = 1'b0;
        push_burst(1, 2);
        vmask = 4'b0110;
        obs_grants.delete();
        cycle();
        check("t5_busy", obs_busy, 0);
        check("t5_winc", obs_winc, 0);
        check("t5_gnt", obs_gnt, NREQ - 1);
        run_drain("t5", 100, n);
        check("t5_first_grant", (obs_grants.size() > 0) ? obs_grants[0] : -1, 1);

        // arb_en dropped mid-burst: burst completes, no new grant.
        push_burst(0, 5);
        push_burst(3, 1);
        vmask = 4'b0001;
        wait_size("t6", 0, 3, 30);
        arb_en = 1'b0;
        vmask  = 4'b1001;
        repeat (10) cycle();
        check("t6_q0", q[0].size(), 0);
        check("t6_q3", q[3].size(), 1);
        check("t6_idle", obs_busy, 0);
        run_drain("t6", 100, n);

        // Randomized traffic with backpressure, gating and occasional resets.
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (q[i].size() == 0 && $urandom_range(0, 3) == 0) push_burst(i, $urandom_range(1, 20));
            end
            vmask  = NREQ'($urandom);
            wfull  = ($urandom_range(0, 4) == 0);
            arb_en = ($urandom_range(0, 9) != 0);
            wrst   = ($urandom_range(0, 299) == 0);
            cycle();
        end
        wrst = 1'b0;
        run_drain("rand", 2000, n);

`ifdef FIFO_WR_ARB_STATS_EN
        for (int i = 0; i < NREQ; i++) check("stat_rand", 32'(stat_beats[i*16 +: 16]), m_stat[i]);

        // 70000 beats from requester 1: counter wraps to 4464.
        wrst = 1'b1;
        cycle();
        wrst   = 1'b0;
        arb_en = 1'b1;
        wfull  = 1'b0;
        vmask  = 4'b0010;
        pushed = 0;
        n = 0;
        while ((pushed < 70000 || q[1].size() > 0 || m_busy) && n < 80000) begin
            while (pushed < 70000 && q[1].size() < 4) begin
                b.data = DSIZE'($urandom);
                b.last = (pushed == 69999);
                q[1].push_back(b);
                pushed++;
            end
            cycle();
            n++;
        end
        check("t7_done", 32'(n < 80000), 1);
        cycle();
        check("t7_stat0", 32'(stat_beats[0 +: 16]), 0);
        check("t7_stat1", 32'(stat_beats[16 +: 16]), 70000 % 65536);
        check("t7_stat2", 32'(stat_beats[32 +: 16]), 0);
        check("t7_stat3", 32'(stat_beats[48 +: 16]), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
